// File: rtl/frame_sched_pkg.sv
// Shared types and constants for the frame scheduler and its round-robin arbiter.
package frame_sched_pkg;

  typedef enum logic [1:0] {
    ST_TRAIN = 2'd0,
    ST_IDLE  = 2'd1,
    ST_BUSY  = 2'd2
  } state_e;

  localparam int FRAME_W = 27;
  localparam int WORD_W  = 9;

  localparam logic [7:0] COMMA = 8'h3C;
  localparam logic       KCODE = 1'b1;

  // Three data words 0_A5, 0_5A, 0_A5 with word 0 in the low bits.
  localparam logic [FRAME_W-1:0] TRAIN_PATTERN = 27'h294B4A5;

endpackage

// File: rtl/frame_scheduler_rr_arbiter.sv
// Combinational round-robin pick: first valid channel at or above ptr, wrapping.
module rr_arbiter #(
  parameter  int NUM_CH = 4,
  localparam int CH_W   = $clog2(NUM_CH)
) (
  input  logic [NUM_CH-1:0] valid,
  input  logic [CH_W-1:0]   ptr,
  output logic              any,
  output logic [CH_W-1:0]   winner,
  output logic [NUM_CH-1:0] onehot
);

  logic [CH_W-1:0] idx;

  always_comb begin
    any    = 1'b0;
    winner = '0;
    onehot = '0;
    idx    = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      idx = CH_W'((int'(ptr) + i) % NUM_CH);
      if (!any && valid[idx]) begin
        any         = 1'b1;
        winner      = idx;
        onehot[idx] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/frame_scheduler.sv
// Round-robin frame scheduler feeding the serializer's start/data inputs.
// Optional link training after reset is built with FRAME_SCHED_TRAIN_EN.
module frame_scheduler
  import frame_sched_pkg::*;
#(
  parameter  int NUM_CH       = 4,
  parameter  int FRAME_CYCLES = 40,
  parameter  int TRAIN_FRAMES = 8,
  localparam int CH_W         = $clog2(NUM_CH)
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic [NUM_CH-1:0]         req_valid_i,
  input  logic [NUM_CH*FRAME_W-1:0] req_data_i,
  output logic [NUM_CH-1:0]         req_ready_o,
  output logic                      start_o,
  output logic [FRAME_W-1:0]        data_o,
  output logic [CH_W-1:0]           grant_ch_o,
  output logic                      busy_o,
  output logic                      link_ready_o
);

  localparam int CNT_W = $clog2(FRAME_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FRAME_CYCLES - 1);

  if (NUM_CH < 2 || NUM_CH > 8 || FRAME_CYCLES < 4 || TRAIN_FRAMES < 1) begin : g_cfg_err
    $error("frame_scheduler: unsupported parameter set");
  end

`ifdef FRAME_SCHED_TRAIN_EN
  localparam state_e RESET_ST = ST_TRAIN;
  localparam int     TR_W     = $clog2(TRAIN_FRAMES + 1);
  localparam logic [TR_W-1:0] TR_LAST = TR_W'(TRAIN_FRAMES - 1);
  logic            tr_busy_q, tr_busy_d;
  logic [TR_W-1:0] tr_cnt_q, tr_cnt_d;
`else
  localparam state_e RESET_ST = ST_IDLE;
`endif

  state_e                            state_q, state_d;
  logic [CNT_W-1:0]                  cnt_q, cnt_d;
  logic [CH_W-1:0]                   ptr_q, ptr_d;
  logic [CH_W-1:0]                   grant_q, grant_d;
  logic [FRAME_W-1:0]                data_q, data_d;
  logic                              start_q, start_d;
  logic [NUM_CH-1:0][FRAME_W-1:0]    req_data;
  logic                              arb_any;
  logic [CH_W-1:0]                   arb_win;
  logic [NUM_CH-1:0]                 arb_oh;
  logic                              accept;

  assign req_data = req_data_i;

  rr_arbiter #(.NUM_CH(NUM_CH)) u_arb (
    .valid  (req_valid_i),
    .ptr    (ptr_q),
    .any    (arb_any),
    .winner (arb_win),
    .onehot (arb_oh)
  );

  // Nothing is offered a handshake while reset is held.
  assign accept       = (state_q == ST_IDLE) && !rst_i;
  assign link_ready_o = accept;
  assign req_ready_o  = accept ? arb_oh : '0;
  assign start_o      = start_q;
  assign data_o       = data_q;
  assign grant_ch_o   = grant_q;

`ifdef FRAME_SCHED_TRAIN_EN
  assign busy_o = (state_q == ST_BUSY) || (state_q == ST_TRAIN && tr_busy_q);
`else
  assign busy_o = (state_q == ST_BUSY);
`endif

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    ptr_d   = ptr_q;
    grant_d = grant_q;
    data_d  = data_q;
    start_d = 1'b0;
`ifdef FRAME_SCHED_TRAIN_EN
    tr_busy_d = tr_busy_q;
    tr_cnt_d  = tr_cnt_q;
`endif
    case (state_q)
`ifdef FRAME_SCHED_TRAIN_EN
      // Each training slot mirrors IDLE->BUSY: one issue cycle, then the frame.
      ST_TRAIN: begin
        if (!tr_busy_q) begin
          start_d   = 1'b1;
          data_d    = TRAIN_PATTERN;
          cnt_d     = '0;
          tr_busy_d = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == CNT_LAST) begin
            tr_busy_d = 1'b0;
            cnt_d     = '0;
            if (tr_cnt_q == TR_LAST) state_d = ST_IDLE;
            else                     tr_cnt_d = tr_cnt_q + 1'b1;
          end
        end
      end
`endif
      ST_IDLE: begin
        if (arb_any) begin
          data_d  = req_data[arb_win];
          grant_d = arb_win;
          ptr_d   = (arb_win == CH_W'(NUM_CH - 1)) ? '0 : arb_win + 1'b1;
          start_d = 1'b1;
          cnt_d   = '0;
          state_d = ST_BUSY;
        end
      end
      ST_BUSY: begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CNT_LAST) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= RESET_ST;
      cnt_q   <= '0;
      ptr_q   <= '0;
      grant_q <= '0;
      data_q  <= '0;
      start_q <= 1'b0;
`ifdef FRAME_SCHED_TRAIN_EN
      tr_busy_q <= 1'b0;
      tr_cnt_q  <= '0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ptr_q   <= ptr_d;
      grant_q <= grant_d;
      data_q  <= data_d;
      start_q <= start_d;
`ifdef FRAME_SCHED_TRAIN_EN
      tr_busy_q <= tr_busy_d;
      tr_cnt_q  <= tr_cnt_d;
`endif
    end
  end

endmodule

// File: doc/frame_scheduler.md
# frame_scheduler

Round-robin scheduler that shares the single serial transmit path between NUM_CH requesters, each offering 27-bit frames (three 9-bit {k, byte} words, word 0 in bits [8:0]). It accepts one frame at a time over a valid/ready handshake, holds the payload stable on the serializer's 27-bit data input, pulses its start, and paces grants so a frame is never disturbed mid-transmission. It sits directly upstream of serializer_in, driving its start_i/data_i. Both blocks share clock and reset.

## Interface
- NUM_CH, 4, number of requesters (2..8)
- FRAME_CYCLES, 40, clock cycles one frame occupies on the serializer (comma + 3 words); must be ≥ 4
- TRAIN_FRAMES, 8, training frames sent after reset (used only with FRAME_SCHED_TRAIN_EN)
- clk_i  in  1  clock; all logic on rising edge
- rst_i  in  1  synchronous, active-high reset
- req_valid_i  in  NUM_CH  per-channel frame valid
- req_data_i  in  NUM_CH*27  channel c payload at [27c+26:27c]
- req_ready_o  out  NUM_CH  one-hot accept; handshake completes when valid & ready
- start_o  out  1  one-cycle start pulse to serializer
- data_o  out  27  frame payload to serializer, held stable between grants
- grant_ch_o  out  $clog2(NUM_CH)  channel of frame currently or last sent
- busy_o  out  1  frame in flight
- link_ready_o  out  1  requests are being accepted

## Operation
- Reset values: req_ready_o 0, start_o 0, data_o 27'h0, grant_ch_o 0, busy_o 0, link_ready_o 0; RR pointer 0 (channel 0 highest priority); frame counter 0.
- States: ST_TRAIN, ST_IDLE, ST_BUSY. After reset: ST_TRAIN with macro, else ST_IDLE.
- ST_IDLE: link_ready_o 1. If any req_valid_i, the winner is the first valid channel searching upward (wrapping) from the RR pointer. req_ready_o[winner] is high that same cycle (combinational from valid and pointer). All other bits stay 0. On that edge:
  - data_o ← winner payload
  - grant_ch_o ← winner
  - pointer ← winner+1 mod NUM_CH
  - start_o ← 1
  - counter ← 0
  - state → ST_BUSY
- With no valid request, the block stays in ST_IDLE. data_o holds and the serializer emits commas.
- ST_BUSY: busy_o 1, req_ready_o all 0. start_o is high only in the first BUSY cycle. The counter increments each cycle. When counter == FRAME_CYCLES-1, the next state is ST_IDLE.
- The pointer advances only on a grant. A channel that drops valid before being granted loses nothing and gets no handshake.
- Payload is captured only at the handshake. Changes to req_data_i after that have no effect.
- Reset mid-frame: every register returns to its reset value next cycle. The in-flight frame is abandoned and not retried.

## Timing
- Grant latency: request valid in an IDLE cycle → ready same cycle → start_o and data_o valid the next cycle.
- Frame slot: FRAME_CYCLES BUSY cycles + at least 1 IDLE cycle, so back-to-back start_o pulses are exactly FRAME_CYCLES+1 cycles apart.
- busy_o rises with start_o and falls after FRAME_CYCLES cycles.
- Simultaneous requests from all channels under continuous load are served strictly in rotation: c, c+1, …

## Configuration
- FRAME_SCHED_TRAIN_EN defined:
  - After reset, ST_TRAIN sends TRAIN_FRAMES frames of TRAIN_PATTERN (27'h294B4A5 = words 0_A5, 0_5A, 0_A5), each slot paced as in ST_BUSY (start pulse + FRAME_CYCLES + 1 gap cycle).
  - link_ready_o and req_ready_o stay 0 throughout training.
  - busy_o is 1 during each training frame.
  - grant_ch_o stays 0.
  - After the last training frame's gap cycle, enter ST_IDLE.
- FRAME_SCHED_TRAIN_EN undefined: ST_TRAIN and its counter are not built. ST_IDLE is entered directly, and link_ready_o goes 1 the first cycle after reset deasserts.

## Structure
- Package frame_sched_pkg:
  - state enum (ST_TRAIN, ST_IDLE, ST_BUSY)
  - COMMA 8'h3C, KCODE 1'b1
  - FRAME_W 27, WORD_W 9
  - TRAIN_PATTERN
- Sub-module rr_arbiter (NUM_CH): combinational winner/one-hot from valid vector and pointer. The pointer register lives in frame_scheduler.

## Test plan
- No macro, ch1 valid with 27'h1234567 in IDLE → ready[1] that cycle; next cycle start_o=1, data_o=27'h1234567, grant_ch_o=1; busy_o high 40 cycles.
- ch0 and ch2 valid continuously from reset → grants 0, 2, 0, 2; start pulses 41 cycles apart.
- All four valid continuously → grant order 0,1,2,3,0; each ready is a single-cycle pulse.
- Macro defined, TRAIN_FRAMES=2, ch0 valid from reset → two starts with data_o=27'h294B4A5 with req_ready_o 0 throughout; the first ch0 grant is in the cycle after training ends, 82 cycles after reset.
- rst_i pulsed 10 cycles into a ch3 frame → next cycle all outputs at reset values and pointer 0; ch3 still valid is regranted first.
- ch2 valid drops before its turn while ch1 is busy → no ready[2]; the pointer skips to the next valid channel.
